// File: rtl/jedro_1_ifu_pf.sv
// jedro_1_ifu_pf -- instruction prefetch unit.
// Streams sequential fetch requests into a small FIFO and presents the head
// instruction to the decoder. A jump flushes the FIFO and restarts the stream.
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   get_next_instr_i        consumer pops the head entry
//   jmp_instr_i,
//   jmp_address_i           redirect the fetch stream to jmp_address_i
//   mem_en_o, mem_addr_o    memory read request (registered)
//   mem_rdata_i             read data, valid one cycle after mem_en_o
//   cinstr_o, cinstr_addr_o head instruction and its address
//   cinstr_valid_o          FIFO non-empty
module jedro_1_ifu_pf #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           FIFO_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  get_next_instr_i,
  input  logic                  jmp_instr_i,
  input  logic [ADDR_WIDTH-1:0] jmp_address_i,
  output logic                  mem_en_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic [DATA_WIDTH-1:0] cinstr_o,
  output logic [ADDR_WIDTH-1:0] cinstr_addr_o,
  output logic                  cinstr_valid_o
);

  localparam int unsigned STEP  = DATA_WIDTH / 8;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SUM_W = CNT_W + 1;
  localparam logic [ADDR_WIDTH-1:0] STEP_A     = ADDR_WIDTH'(STEP);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(STEP - 1);

  typedef enum logic {BOOT, RUN} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] addr_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      rptr_q, wptr_q;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  inflight_q;   // a live response is on mem_rdata_i this cycle
  logic [ADDR_WIDTH-1:0] pc_q;
  logic [ADDR_WIDTH-1:0] resp_addr_q;  // address belonging to the current response

  logic                  jump, push, pop, issue;
  logic [SUM_W-1:0]      pending;
  logic [ADDR_WIDTH-1:0] target;

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    jump    = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    issue   = 1'b0;
    count_d = count_q;
    target  = jmp_address_i & ALIGN_MASK;
    // Every entry that is stored, being returned, or requested on the bus
    // already owns a FIFO slot; a new request needs a free one.
    pending = SUM_W'(count_q) + SUM_W'(inflight_q) + SUM_W'(mem_en_o);
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        jump  = jmp_instr_i;
        push  = inflight_q & ~jmp_instr_i;
        pop   = get_next_instr_i & (count_q != '0) & ~jmp_instr_i;
        issue = ~jmp_instr_i & (pending < SUM_W'(FIFO_DEPTH));
      end
      default: state_d = BOOT;
    endcase
    if (jump) begin
      count_d = '0;
    end else if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // State, fetch PC and request registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= BOOT;
      pc_q           <= RESET_ADDR;
      mem_en_o       <= 1'b0;
      mem_addr_o     <= RESET_ADDR;
      resp_addr_q    <= '0;
      inflight_q     <= 1'b0;
      count_q        <= '0;
      cinstr_valid_o <= 1'b0;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      cinstr_valid_o <= (count_d != '0);
      resp_addr_q    <= mem_addr_o;
      // A jump kills the response to the request currently on the bus.
      inflight_q     <= mem_en_o & ~jump;
      mem_en_o       <= jump | issue;
      if (jump) begin
        mem_addr_o <= target;
        pc_q       <= target + STEP_A;
      end else if (issue) begin
        mem_addr_o <= pc_q;
        pc_q       <= pc_q + STEP_A;
      end
    end
  end

  // FIFO storage and pointers; a jump flushes by resetting both pointers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rptr_q <= '0;
      wptr_q <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        data_q[i] <= '0;
        addr_q[i] <= '0;
      end
    end else if (jump) begin
      rptr_q <= '0;
      wptr_q <= '0;
    end else begin
      if (push) begin
        data_q[wptr_q] <= mem_rdata_i;
        addr_q[wptr_q] <= resp_addr_q;
        wptr_q         <= wptr_q + PTR_W'(1);
      end
      if (pop) begin
        rptr_q <= rptr_q + PTR_W'(1);
      end
    end
  end

  assign cinstr_o      = data_q[rptr_q];
  assign cinstr_addr_o = addr_q[rptr_q];

endmodule
